// File: rtl/panel_pkg.sv
// Shared definitions for the LED panel scan path: FSM encodings, default
// panel geometry and the bit layout of one RGB triplet in a frame-buffer word.
package panel_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  localparam int PIX_R    = 0;
  localparam int PIX_G    = 1;
  localparam int PIX_B    = 2;
  localparam int PIX_BITS = 3;

  typedef logic [2:0] scan_state_t;

  localparam scan_state_t ST_IDLE    = 3'd0;
  localparam scan_state_t ST_FETCH   = 3'd1;
  localparam scan_state_t ST_SHIFT   = 3'd2;
  localparam scan_state_t ST_BLANK   = 3'd3;
  localparam scan_state_t ST_ADVANCE = 3'd4;
  localparam scan_state_t ST_LATCH   = 3'd5;
  localparam scan_state_t ST_DISPLAY = 3'd6;

  // LEDs are dark only while the panel row counter or latch is being touched.
  function automatic logic is_blanked(input scan_state_t st);
    return (st == ST_IDLE) || (st == ST_BLANK) || (st == ST_ADVANCE) || (st == ST_LATCH);
  endfunction

endpackage

// File: rtl/panel_shift_out.sv
// Serialises one row of RGB triplets, highest column first, with a divided
// shift clock; data changes only on the falling sclk transition.
module panel_shift_out
  import panel_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int CLK_DIV = 1
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     load,
  input  logic [PIX_BITS*COLS-1:0] load_data,
  output logic                     sclk,
  output logic                     red,
  output logic                     green,
  output logic                     blue,
  output logic                     done
);

  localparam int WORD_W = PIX_BITS * COLS;
  localparam int TOP    = PIX_BITS * (COLS - 1);
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [WORD_W-1:0] data_reg;
  logic [COL_W-1:0]  col_reg;
  logic [DIV_W-1:0]  div_reg;
  logic              active_reg;
  logic              sclk_reg;
  logic              phase_end;

  assign phase_end = active_reg && (div_reg == DIV_LAST);
  // High during the final high-phase cycle so the caller leaves on the same edge sclk falls.
  assign done      = phase_end && sclk_reg && (col_reg == '0);

  always_ff @(posedge clk) begin
    if (srst) begin
      data_reg   <= '0;
      col_reg    <= '0;
      div_reg    <= '0;
      active_reg <= 1'b0;
      sclk_reg   <= 1'b0;
    end else if (load) begin
      data_reg   <= load_data;
      col_reg    <= COL_LAST;
      div_reg    <= '0;
      active_reg <= 1'b1;
      sclk_reg   <= 1'b0;
    end else if (active_reg) begin
      if (phase_end) begin
        div_reg  <= '0;
        sclk_reg <= ~sclk_reg;
        if (sclk_reg) begin
          // Shifting past the last column leaves zeros, so the data lines idle low.
          data_reg <= data_reg << PIX_BITS;
          col_reg  <= col_reg - 1'b1;
          if (col_reg == '0) begin
            active_reg <= 1'b0;
          end
        end
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end

  assign sclk  = sclk_reg;
  assign red   = data_reg[TOP + PIX_R];
  assign green = data_reg[TOP + PIX_G];
  assign blue  = data_reg[TOP + PIX_B];

endmodule

// File: rtl/panel_scan_ctrl.sv
// Row-scan sequencer: fetches a row from the frame buffer, shifts it out,
// steps the panel row counter, latches, holds the row lit and swaps banks.
module panel_scan_ctrl
  import panel_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int CLK_DIV   = 1,
  parameter int ON_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    swap_req,
  output logic                    swap_ack,
  output logic                    fb_bank,
  output logic [$clog2(ROWS)-1:0] fb_raddr,
  input  logic [3*COLS-1:0]       fb_rdata,
  output logic                    red_out,
  output logic                    green_out,
  output logic                    blue_out,
  output logic                    sclk_out,
  output logic                    latch_out,
  output logic                    blank_out,
  output logic                    aclk_out,
  output logic                    arst_out
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(ON_CYCLES + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  scan_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             bank_reg, bank_next;
  logic             swap_next;
  logic             load;
  logic             shift_done;
  logic             blank_reg;
  logic             latch_reg;
  logic             aclk_reg;
  logic             arst_reg;
  logic             swap_ack_reg;

  // cnt_reg is shared: FETCH and ADVANCE use it as a 2-step phase, DISPLAY as the on-time counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    bank_next  = bank_reg;
    swap_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_FETCH;
          cnt_next   = '0;
        end
      end
      ST_FETCH: begin
        if (cnt_reg == '0) cnt_next = CNT_W'(1);
        else               state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_done) state_next = ST_BLANK;
      end
      ST_BLANK: begin
        state_next = ST_ADVANCE;
        cnt_next   = '0;
      end
      ST_ADVANCE: begin
        if (cnt_reg == '0) cnt_next = CNT_W'(1);
        else               state_next = ST_LATCH;
      end
      ST_LATCH: begin
        state_next = ST_DISPLAY;
        cnt_next   = '0;
      end
      ST_DISPLAY: begin
        if (cnt_reg == ON_LAST) begin
          cnt_next   = '0;
          row_next   = row_reg + 1'b1;
          state_next = enable ? ST_FETCH : ST_IDLE;
          // Bank ownership only changes at a frame boundary, never mid-frame.
          if ((row_reg == ROW_LAST) && swap_req) begin
            bank_next = ~bank_reg;
            swap_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // fb_rdata is valid in the second FETCH cycle, so capture it on that edge.
  assign load = (state_reg == ST_FETCH) && (cnt_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      row_reg      <= '0;
      bank_reg     <= 1'b0;
      blank_reg    <= 1'b1;
      latch_reg    <= 1'b0;
      aclk_reg     <= 1'b0;
      arst_reg     <= 1'b0;
      swap_ack_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      row_reg      <= row_next;
      bank_reg     <= bank_next;
      blank_reg    <= is_blanked(state_next);
      latch_reg    <= (state_next == ST_LATCH);
      arst_reg     <= (state_reg == ST_BLANK) && (row_reg == '0);
      aclk_reg     <= (state_reg == ST_BLANK) && (row_reg != '0);
      swap_ack_reg <= swap_next;
    end
  end

  panel_shift_out #(
    .COLS    (COLS),
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (clk),
    .srst      (reset),
    .load      (load),
    .load_data (fb_rdata),
    .sclk      (sclk_out),
    .red       (red_out),
    .green     (green_out),
    .blue      (blue_out),
    .done      (shift_done)
  );

  assign fb_raddr  = row_reg;
  assign fb_bank   = bank_reg;
  assign swap_ack  = swap_ack_reg;
  assign blank_out = blank_reg;
  assign latch_out = latch_reg;
  assign aclk_out  = aclk_reg;
  assign arst_out  = arst_reg;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// Bench for panel_scan_ctrl: a default instance for row/frame/swap/enable
// scenarios and a short-frame CLK_DIV=2 instance for reset during shifting.
module tb_panel_scan_ctrl;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int WORD_W = 3 * COLS;
  localparam int RP     = 38;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, enable, swap_req;
  logic              swap_ack, fb_bank;
  logic [2:0]        fb_raddr;
  logic [WORD_W-1:0] fb_rdata;
  logic              red_out, green_out, blue_out, sclk_out;
  logic              latch_out, blank_out, aclk_out, arst_out;

  logic              reset2, enable2, swap_req2;
  logic              swap_ack2, fb_bank2;
  logic [0:0]        fb_raddr2;
  logic [WORD_W-1:0] fb_rdata2;
  logic              red2, green2, blue2, sclk2, latch2, blank2, aclk2, arst2;

  logic [WORD_W-1:0] mem [2][ROWS];

  always @(posedge clk) begin
    fb_rdata  <= mem[fb_bank][fb_raddr];
    fb_rdata2 <= mem[fb_bank2][{2'b00, fb_raddr2}];
  end

  panel_scan_ctrl u_dut (
    .clk(clk), .reset(reset), .enable(enable), .swap_req(swap_req),
    .swap_ack(swap_ack), .fb_bank(fb_bank), .fb_raddr(fb_raddr), .fb_rdata(fb_rdata),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out), .sclk_out(sclk_out),
    .latch_out(latch_out), .blank_out(blank_out), .aclk_out(aclk_out), .arst_out(arst_out)
  );

  panel_scan_ctrl #(.ROWS(2), .COLS(COLS), .CLK_DIV(2), .ON_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset2), .enable(enable2), .swap_req(swap_req2),
    .swap_ack(swap_ack2), .fb_bank(fb_bank2), .fb_raddr(fb_raddr2), .fb_rdata(fb_rdata2),
    .red_out(red2), .green_out(green2), .blue_out(blue2), .sclk_out(sclk2),
    .latch_out(latch2), .blank_out(blank2), .aclk_out(aclk2), .arst_out(arst2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nbits = 0;
  int sclk_rises = 0, aclk_cnt = 0, arst_cnt = 0, latch_cnt = 0, ack_cnt = 0;
  logic sclk_prev = 1'b0;
  logic [WORD_W-1:0] acc = '0;
  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] got_q[$];

  // Advance to the next falling edge and record pulses / shifted bits of the default instance.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (sclk_out && !sclk_prev) begin
      acc[3*(COLS-1-nbits) +: 3] = {blue_out, green_out, red_out};
      nbits++;
      sclk_rises++;
      if (nbits == COLS) begin
        got_q.push_back(acc);
        nbits = 0;
      end
    end
    sclk_prev = sclk_out;
    if (aclk_out) aclk_cnt++;
    if (arst_out) arst_cnt++;
    if (latch_out) latch_cnt++;
    if (swap_ack) ack_cnt++;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    reset = 1'b1; enable = 1'b1; swap_req = 1'b0;
    reset2 = 1'b1; enable2 = 1'b0; swap_req2 = 1'b0;
    repeat (3) step();
    obs = {blank_out, sclk_out, red_out, green_out, blue_out, latch_out, aclk_out,
           arst_out, swap_ack, fb_bank, fb_raddr};
    checks++;
    if (obs !== {1'b1, 12'b0}) begin
      errors++; $display("FAIL reset_state: got %b expected %b", obs, {1'b1, 12'b0});
    end
    enable = 1'b0; reset = 1'b0;
    repeat (2) step();
    obs = {blank_out, sclk_out, red_out, green_out, blue_out, latch_out, aclk_out,
           arst_out, swap_ack, fb_bank, fb_raddr};
    checks++;
    if (obs !== {1'b1, 12'b0}) begin
      errors++; $display("FAIL idle_hold: got %b expected %b", obs, {1'b1, 12'b0});
    end
    $display("reset: idle state observed");
  endtask

  task automatic test_first_row();
    logic [9:0] obs, expv;
    logic [WORD_W-1:0] got_w, exp_w;
    int s0;
    enable = 1'b1;
    cyc = 0;
    s0 = sclk_rises;
    exp_q.push_back(mem[0][0]);
    for (int c = 1; c <= RP; c++) begin
      step();
      expv = {(c >= 19 && c <= 22), (c == 20), 1'b0, (c == 22),
              (c >= 3 && c <= 18 && ((c - 3) % 2 == 1)), 1'b0, 1'b0, 3'd0};
      obs = {blank_out, arst_out, aclk_out, latch_out, sclk_out, swap_ack, fb_bank, fb_raddr};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL row0_timing cycle %0d: got %b expected %b", c, obs, expv);
      end
      if (c == 4) begin
        checks++;
        if ({blue_out, green_out, red_out} !== 3'b001) begin
          errors++; $display("FAIL first_bit: got bgr %b expected 001", {blue_out, green_out, red_out});
        end
      end
      if (c == 18) begin
        checks++;
        if ({blue_out, green_out, red_out} !== 3'b100) begin
          errors++; $display("FAIL eighth_bit: got bgr %b expected 100", {blue_out, green_out, red_out});
        end
      end
    end
    checks++;
    if (sclk_rises - s0 !== COLS) begin
      errors++; $display("FAIL sclk_rises: got %0d expected %0d", sclk_rises - s0, COLS);
    end
    checks++;
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      errors++; $display("FAIL row0_data: got %0d rows expected 1", got_q.size());
    end else begin
      got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
      if (got_w !== exp_w) begin
        errors++; $display("FAIL row0_data: got %h expected %h", got_w, exp_w);
      end else $display("row data %h matched", got_w);
    end
  endtask

  // Row 0 was covered above; rows 1..7 complete the first frame (cycles 1..304).
  // swap_req is raised in row 2 and withdrawn in row 5, so no swap may follow.
  task automatic test_full_frame(input int a0, input int r0, input int l0);
    logic [WORD_W-1:0] got_w, exp_w;
    for (int k = 1; k < ROWS; k++) begin
      step();
      checks++;
      if (fb_raddr !== 3'(k)) begin
        errors++; $display("FAIL raddr_seq row %0d: got %0d expected %0d", k, fb_raddr, k);
      end
      exp_q.push_back(mem[0][k]);
      if (k == 2) swap_req = 1'b1;
      if (k == 5) swap_req = 1'b0;
      repeat (RP - 1) step();
    end
    checks++;
    if (aclk_cnt - a0 !== 7 || arst_cnt - r0 !== 1 || latch_cnt - l0 !== 8) begin
      errors++;
      $display("FAIL frame_pulses: got aclk %0d arst %0d latch %0d expected 7 1 8",
               aclk_cnt - a0, arst_cnt - r0, latch_cnt - l0);
    end
    for (int i = 1; i < ROWS; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL frame1_data row %0d: no row captured", i);
      end else begin
        got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++; $display("FAIL frame1_data row %0d: got %h expected %h", i, got_w, exp_w);
        end else $display("row data %h matched", got_w);
      end
    end
  endtask

  task automatic test_swap();
    logic [WORD_W-1:0] got_w, exp_w;
    int k0;
    k0 = ack_cnt;
    for (int k = 0; k < ROWS; k++) begin
      step();
      checks++;
      if (fb_raddr !== 3'(k) || fb_bank !== 1'b0) begin
        errors++; $display("FAIL frame2_addr row %0d: got row %0d bank %0d expected row %0d bank 0",
                           k, fb_raddr, fb_bank, k);
      end
      if (k == 0) begin
        checks++;
        if (swap_ack !== 1'b0) begin
          errors++; $display("FAIL swap_cancel: got ack %b expected 0", swap_ack);
        end
      end
      exp_q.push_back(mem[0][k]);
      if (k == 3) swap_req = 1'b1;
      repeat (RP - 1) step();
    end
    checks++;
    if (ack_cnt - k0 !== 0) begin
      errors++; $display("FAIL ack_midframe: got %0d acks expected 0", ack_cnt - k0);
    end
    step();
    checks++;
    if ({swap_ack, fb_bank, fb_raddr} !== 5'b11_000) begin
      errors++; $display("FAIL swap_boundary: got ack/bank/raddr %b expected 11000",
                         {swap_ack, fb_bank, fb_raddr});
    end
    swap_req = 1'b0;
    exp_q.push_back(mem[1][0]);
    step();
    checks++;
    if ({swap_ack, fb_bank} !== 2'b01) begin
      errors++; $display("FAIL swap_single: got ack/bank %b expected 01", {swap_ack, fb_bank});
    end
    repeat (RP - 2) step();
    for (int i = 0; i < ROWS; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL frame2_data row %0d: no row captured", i);
      end else begin
        got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++; $display("FAIL frame2_data row %0d: got %h expected %h", i, got_w, exp_w);
        end else $display("row data %h matched", got_w);
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [WORD_W-1:0] got_w, exp_w;
    int l0, s0;
    step();
    checks++;
    if (fb_raddr !== 3'd1) begin
      errors++; $display("FAIL raddr_row1: got %0d expected 1", fb_raddr);
    end
    exp_q.push_back(mem[1][1]);
    repeat (RP - 1) step();
    step();
    exp_q.push_back(mem[1][2]);
    repeat (5) step();
    enable = 1'b0;
    l0 = latch_cnt;
    repeat (32) step();
    checks++;
    if (blank_out !== 1'b0 || latch_cnt - l0 !== 1) begin
      errors++; $display("FAIL drop_finish: got blank %b latches %0d expected 0 1", blank_out, latch_cnt - l0);
    end
    step();
    checks++;
    if ({blank_out, sclk_out, fb_raddr} !== 5'b10_011) begin
      errors++; $display("FAIL drop_idle: got %b expected 10011", {blank_out, sclk_out, fb_raddr});
    end
    s0 = sclk_rises;
    repeat (7) step();
    checks++;
    if (blank_out !== 1'b1 || sclk_rises != s0 || fb_raddr !== 3'd3) begin
      errors++; $display("FAIL idle_stay: got blank %b rises %0d raddr %0d expected 1 0 3",
                         blank_out, sclk_rises - s0, fb_raddr);
    end
    enable = 1'b1;
    step();
    checks++;
    if (blank_out !== 1'b0 || fb_raddr !== 3'd3) begin
      errors++; $display("FAIL resume_row3: got blank %b raddr %0d expected 0 3", blank_out, fb_raddr);
    end
    exp_q.push_back(mem[1][3]);
    repeat (RP - 1) step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL frame3_data row %0d: no row captured", i);
      end else begin
        got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
        if (got_w !== exp_w) begin
          errors++; $display("FAIL frame3_data row %0d: got %h expected %h", i, got_w, exp_w);
        end else $display("row data %h matched", got_w);
      end
    end
  endtask

  // Short frame (2 rows, 40-cycle rows) so a swap happens before the mid-shift reset.
  task automatic test_reset_mid_shift();
    logic [10:0] obs;
    enable = 1'b0;
    reset2 = 1'b0; enable2 = 1'b1; swap_req2 = 1'b1;
    for (int c = 1; c <= 86; c++) begin
      step();
      if (c == 4 || c == 5) begin
        checks++;
        if (sclk2 !== (c == 5)) begin
          errors++; $display("FAIL div2_first_rise cycle %0d: got sclk %b expected %b", c, sclk2, (c == 5));
        end
      end
      if (c == 81) begin
        checks++;
        if ({swap_ack2, fb_bank2} !== 2'b11) begin
          errors++; $display("FAIL div2_swap: got ack/bank %b expected 11", {swap_ack2, fb_bank2});
        end
        swap_req2 = 1'b0;
      end
    end
    checks++;
    if ({sclk2, fb_bank2} !== 2'b11) begin
      errors++; $display("FAIL div2_midshift: got sclk/bank %b expected 11", {sclk2, fb_bank2});
    end
    reset2 = 1'b1;
    step();
    obs = {sclk2, blank2, fb_bank2, latch2, aclk2, arst2, swap_ack2, red2, green2, blue2, fb_raddr2};
    checks++;
    if (obs !== 11'b010_0000_0000) begin
      errors++; $display("FAIL reset_midshift: got %b expected 01000000000", obs);
    end
    reset2 = 1'b0; enable2 = 1'b0;
    repeat (3) step();
    checks++;
    if ({sclk2, blank2, fb_bank2, fb_raddr2} !== 4'b0100) begin
      errors++; $display("FAIL reset_idle: got %b expected 0100", {sclk2, blank2, fb_bank2, fb_raddr2});
    end
    $display("reset mid-shift scenario complete");
  endtask

  initial begin
    int a0, r0, l0;
    for (int r = 0; r < ROWS; r++) begin
      mem[0][r] = WORD_W'($urandom);
      mem[1][r] = ~mem[0][r];
    end
    mem[0][0] = 24'h2A5B64;
    mem[1][0] = 24'h5D3A91;
    test_reset();
    a0 = aclk_cnt; r0 = arst_cnt; l0 = latch_cnt;
    test_first_row();
    test_full_frame(a0, r0, l0);
    test_swap();
    test_enable_drop();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_scan_ctrl.md
# panel_scan_ctrl

Row-scan sequencer for the single LED panel driver. It fetches one row of RGB pixel data per scan slot from the double-buffered frame buffer and shifts it out on `red_out`/`green_out`/`blue_out` with `sclk_out`. It then blanks the panel, advances the panel row counter through `aclk_out`/`arst_out`, latches, and holds the row lit. It also arbitrates frame-buffer bank ownership between itself and the UART-fed frame writer, using a swap handshake at frame boundaries.

## Interface
Parameters:
- `ROWS`, 8: panel rows per frame; power of 2, ≥2.
- `COLS`, 8: pixels per row, ≥1.
- `CLK_DIV`, 1: `clk` cycles per `sclk_out` half-period, ≥1.
- `ON_CYCLES`, 16: `clk` cycles a row is held lit after latch, ≥1.

Ports (clock and reset are `clk` and `reset`; one clock domain; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when high, scanning runs; when low, scanning stops at the next row boundary.
- `swap_req` in 1: level from writer; "back bank complete".
- `swap_ack` out 1: one-cycle pulse; bank ownership flipped.
- `fb_bank` out 1: bank currently scanned; the writer owns `~fb_bank`.
- `fb_raddr` out clog2(ROWS): row address to frame buffer.
- `fb_rdata` in 3*COLS: registered read data, valid 1 cycle after `fb_raddr`; `[3c+2:3c]` = {b,g,r} of column c.
- `red_out`, `green_out`, `blue_out` out 1 each: serial pixel data.
- `sclk_out` out 1: shift clock; panel samples on its rising edge.
- `latch_out` out 1: latch pulse.
- `blank_out` out 1: high = LEDs off.
- `aclk_out` out 1: row-counter increment pulse.
- `arst_out` out 1: row-counter reset pulse.

## Operation
- States: IDLE, FETCH, SHIFT, BLANK, ADVANCE, LATCH, DISPLAY.
- IDLE (after reset):
  - All outputs 0 except `blank_out`=1.
  - Row counter `row`=0, `fb_bank`=0.
  - `enable`=1 → FETCH.
- FETCH, 2 cycles:
  - Cycle 0 drives `fb_raddr`=`row`.
  - Cycle 1 captures `fb_rdata` into the shift register → SHIFT.
- SHIFT:
  - Shift COLS bits, column COLS-1 first, column 0 last.
  - Each bit: `sclk_out` low for CLK_DIV cycles with data valid, then high for CLK_DIV cycles.
  - Data is stable across the rising edge.
  - After the last high phase, `sclk_out` returns low → BLANK.
- BLANK, 1 cycle: `blank_out`=1.
- ADVANCE, 2 cycles:
  - First cycle: `arst_out`=1 if `row`==0, else `aclk_out`=1.
  - Second cycle: both low.
- LATCH, 1 cycle: `latch_out`=1.
- DISPLAY:
  - `blank_out`=0 for ON_CYCLES cycles.
  - Then `row` increments, wrapping ROWS-1→0.
  - `enable`=1 → FETCH, else IDLE with `blank_out`=1.
- Display during the next row's FETCH/SHIFT: `blank_out` stays 0 through them, so the previous row stays lit.
- Blanking rule: `blank_out` is high only in IDLE, BLANK, ADVANCE, LATCH.
- Swap arbitration:
  - Checked on the last DISPLAY cycle when `row`==ROWS-1 (frame boundary).
  - If `swap_req`=1: `fb_bank` toggles and `swap_ack` pulses for that one cycle.
  - Never mid-frame.
  - `swap_req` asserted mid-frame is held pending by the writer until ack.
  - `swap_req` deasserting before the boundary cancels the swap.
- `enable` dropping mid-row: the current row completes through DISPLAY, then IDLE. Re-enable resumes at the stored `row`.
- `reset` mid-operation: next cycle all state returns to IDLE values. Any partial shift is discarded; `fb_bank` returns to 0.

## Timing
- Row period (enable held): 2 + 2·COLS·CLK_DIV + 1 + 2 + 1 + ON_CYCLES cycles; 38 with defaults.
- Frame period: ROWS × row period; 304 with defaults.
- From `enable` rising in IDLE: `fb_raddr` valid the next cycle; first `sclk_out` rise at cycle 3+CLK_DIV.
- `swap_ack` and the `fb_bank` toggle occur on the same clock edge; `fb_raddr` for row 0 of the new frame uses the new bank.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Structure
- Shared package `panel_pkg`:
  - State enum.
  - Default `ROWS`/`COLS` constants.
  - Pixel-triplet bit offsets (R=0, G=1, B=2).
- Sub-module `panel_shift_out`:
  - Parallel load, serialise COLS RGB triplets, generate `sclk_out` with divider.
  - `done` pulse.
  - Instantiated once.
- Row counter, swap logic and FSM live in the top module.

## Test plan
- Reset then `enable`=1, defaults:
  - `blank_out`=1 during reset.
  - First `arst_out` pulse at cycle 20.
  - `latch_out` at cycle 22.
  - `blank_out` low cycles 23–38.
- Row data 0x…, column 7 = red only, column 0 = blue only: first bit shifted has r=1,g=0,b=0; eighth bit has b=1; exactly 8 `sclk_out` rises per row.
- Full frame: 7 `aclk_out` pulses and 1 `arst_out` per 304 cycles; `fb_raddr` sequence 0..7 then 0.
- `swap_req`=1 asserted during row 3: `swap_ack` single pulse on the last DISPLAY cycle of row 7; `fb_bank` 0→1; no ack mid-frame.
- `enable`=0 during SHIFT of row 2: row 2 finishes latch+DISPLAY, then IDLE with `blank_out`=1; re-enable fetches row 3.
- `reset` asserted mid-SHIFT with CLK_DIV=2: next cycle `sclk_out`=0, `blank_out`=1, `fb_bank`=0, state IDLE.
